synth_voice_mixer: RTL and testbench

Parametrised N-voice synthesiser core. It replaces fixed per-channel oscillator instances and the two-input adder with one time-multiplexed engine. Once per sample period it sweeps all voices, one voice per clock, and sums their waveforms into a single unsigned sample. The result feeds audio_pwm_generator. Voice pitch and waveform are run-time configurable through a write port, and per-voice gates replace fixed enables.

---
 rtl/synth_pkg.sv | 23 ++
 rtl/synth_voice_mixer_wave_shaper.sv | 29 ++
 rtl/synth_voice_mixer.sv | 138 +++++++++++++
 tb/tb_synth_voice_mixer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types for the time-multiplexed voice mixer.
// Waveform codes, sweep FSM states and the mix width helper.
package synth_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'b00,
    WAVE_SAW    = 2'b01,
    WAVE_TRI    = 2'b10,
    WAVE_OFF    = 2'b11
  } waveform_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SWEEP = 2'b01,
    DONE  = 2'b10
  } mixer_state_t;

  // Width that holds the sum of num_voices full-scale samples.
  function automatic int mix_width(int sample_w, int num_voices);
    return sample_w + $clog2(num_voices);
  endfunction

endpackage

// File: rtl/synth_voice_mixer_wave_shaper.sv
// Combinational waveform generator shared by every voice slot.
// Maps the top phase bits to a square, saw or triangle sample.
module wave_shaper
  import synth_pkg::*;
#(
  parameter int SAMPLE_W = 11
) (
  input  logic [SAMPLE_W-1:0] p,
  input  waveform_t           wave,
  output logic [SAMPLE_W-1:0] sample
);

  logic [SAMPLE_W-1:0] t;

  assign t = {p[SAMPLE_W-2:0], 1'b0};

  // Select the waveform shape for the current phase.
  always_comb begin
    sample = '0;
    unique case (wave)
      WAVE_SQUARE: sample = {SAMPLE_W{p[SAMPLE_W-1]}};
      WAVE_SAW:    sample = p;
      WAVE_TRI:    sample = p[SAMPLE_W-1] ? ~t : t;
      WAVE_OFF:    sample = '0;
      default:     sample = '0;
    endcase
  end

endmodule

// File: rtl/synth_voice_mixer.sv
// N-voice synthesiser: one voice per clock, summed once per sample.
// Config writes land in shadow regs and go live on the tick.
module synth_voice_mixer
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 11,
  parameter int PHASE_W    = 16,
  parameter int TICK_DIV   = 1024,
  localparam int VID_W     = $clog2(NUM_VOICES),
  localparam int OUT_W     = mix_width(SAMPLE_W, NUM_VOICES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [VID_W-1:0]      cfg_voice,
  input  logic [PHASE_W-1:0]    cfg_phase_inc,
  input  logic [1:0]            cfg_waveform,
  input  logic [NUM_VOICES-1:0] gate,
  output logic [OUT_W-1:0]      sample_out,
  output logic                  sample_valid,
  output logic                  busy
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0]   cnt;
  logic               tick;
  mixer_state_t       state_q;
  mixer_state_t       state_d;
  logic [VID_W-1:0]   vidx;
  logic               last;
  logic [OUT_W-1:0]   acc;
  logic [OUT_W-1:0]   acc_next;
  logic               cur_gate;
  logic               cur_on;
  logic [SAMPLE_W-1:0] cur_p;
  logic [SAMPLE_W-1:0] cur_sample;

  logic [PHASE_W-1:0] phase   [NUM_VOICES];
  logic [PHASE_W-1:0] sh_inc  [NUM_VOICES];
  waveform_t          sh_wave [NUM_VOICES];
  logic [PHASE_W-1:0] act_inc [NUM_VOICES];
  waveform_t          act_wave[NUM_VOICES];

  assign tick = (cnt == CNT_W'(TICK_DIV - 1));
  assign last = (vidx == VID_W'(NUM_VOICES - 1));
  assign busy = (state_q == SWEEP);

  // Free-running sample-period divider.
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  // Shadow capture on write, shadow-to-active copy on tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        sh_inc[i]   <= '0;
        sh_wave[i]  <= WAVE_OFF;
        act_inc[i]  <= '0;
        act_wave[i] <= WAVE_OFF;
      end
    end else begin
      if (cfg_we && (int'(cfg_voice) < NUM_VOICES)) begin
        sh_inc[cfg_voice]  <= cfg_phase_inc;
        sh_wave[cfg_voice] <= waveform_t'(cfg_waveform);
      end
      if (tick) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          act_inc[i]  <= sh_inc[i];
          act_wave[i] <= sh_wave[i];
        end
      end
    end
  end

  assign cur_gate = gate[vidx];
  assign cur_on   = cur_gate && (act_wave[vidx] != WAVE_OFF);
  assign cur_p    = phase[vidx][PHASE_W-1 -: SAMPLE_W];

  wave_shaper #(
    .SAMPLE_W (SAMPLE_W)
  ) u_shaper (
    .p      (cur_p),
    .wave   (act_wave[vidx]),
    .sample (cur_sample)
  );

  assign acc_next = cur_on ? acc + OUT_W'(cur_sample) : acc;

  // Sweep state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Sweep next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (tick) state_d = SWEEP;
      SWEEP:   if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-voice accumulate, phase update and sample publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      vidx         <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) phase[i] <= '0;
    end else begin
      sample_valid <= 1'b0;
      if (state_q == IDLE && tick) begin
        acc  <= '0;
        vidx <= '0;
      end
      if (state_q == SWEEP) begin
        acc  <= acc_next;
        vidx <= vidx + 1'b1;
        if (cur_gate) phase[vidx] <= phase[vidx] + act_inc[vidx];
        else          phase[vidx] <= '0;
        if (last) begin
          sample_out   <= acc_next;
          sample_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_synth_voice_mixer.sv
// Directed bench for synth_voice_mixer with 4 voices, TICK_DIV=16.
// Expected samples are hand-derived from the phase arithmetic.
module tb_synth_voice_mixer;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_voice;
  logic [15:0] cfg_phase_inc;
  logic [1:0]  cfg_waveform;
  logic [3:0]  gate;
  logic [12:0] sample_out;
  logic        sample_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  synth_voice_mixer #(
    .NUM_VOICES (4),
    .SAMPLE_W   (11),
    .PHASE_W    (16),
    .TICK_DIV   (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_we        (cfg_we),
    .cfg_voice     (cfg_voice),
    .cfg_phase_inc (cfg_phase_inc),
    .cfg_waveform  (cfg_waveform),
    .gate          (gate),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait for the next valid pulse (bounded) and return the sample.
  task automatic get_sample(output int v);
    int n;
    n = 0;
    @(negedge clk);
    while (!sample_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("valid_timeout", int'(sample_valid), 1);
    v = int'(sample_out);
  endtask

  task automatic cfg(input int v, input int inc, input int w);
    cfg_we        = 1'b1;
    cfg_voice     = 2'(v);
    cfg_phase_inc = 16'(inc);
    cfg_waveform  = 2'(w);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Count 63 cycles after reset release and measure pulse timing.
  task automatic idle_window(input string tag);
    int first_v, first_b, nv, nb, gap_bad, last_v, nz;
    first_v = -1; first_b = -1; nv = 0; nb = 0;
    gap_bad = 0; last_v = -1; nz = 0;
    for (int n = 1; n < 64; n++) begin
      @(negedge clk);
      if (busy) begin
        nb++;
        if (first_b < 0) first_b = n;
      end
      if (sample_valid) begin
        nv++;
        if (first_v < 0) first_v = n;
        if (last_v >= 0 && n - last_v != 16) gap_bad++;
        last_v = n;
        if (sample_out != 0) nz++;
      end
    end
    chk({tag, "_first_busy"}, first_b, 16);
    chk({tag, "_first_valid"}, first_v, 20);
    chk({tag, "_valid_count"}, nv, 3);
    chk({tag, "_busy_cycles"}, nb, 12);
    chk({tag, "_period"}, gap_bad, 0);
    chk({tag, "_sample_zero"}, nz, 0);
  endtask

  initial begin
    int s;
    int tri_exp [6];
    tri_exp = '{0, 512, 1024, 1536, 2047, 1535};
    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_voice = '0;
    cfg_phase_inc = '0;
    cfg_waveform = 2'b11;
    gate = 4'b0000;

    @(negedge clk);
    @(negedge clk);
    chk("rst_sample_out", int'(sample_out), 0);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    idle_window("idle");

    get_sample(s);
    chk("idle_extra", s, 0);

    // Voice 0 saw, 0x0800 per sample.
    cfg(0, 16'h0800, 1);
    gate = 4'b0001;
    for (int k = 0; k < 33; k++) begin
      get_sample(s);
      if (k < 3 || k == 31) chk($sformatf("saw_%0d", k), s, 64 * k);
      if (k == 32) chk("saw_wrap", s, 0);
    end

    // Voice 1 square at half-rate toggling.
    gate = 4'b0010;
    cfg(1, 16'h8000, 0);
    for (int k = 0; k < 4; k++) begin
      get_sample(s);
      chk($sformatf("sq1_%0d", k), s, (k % 2) ? 2047 : 0);
    end

    // All four voices square: full-scale sum without overflow.
    gate = 4'b0000;
    for (int v = 0; v < 4; v++) cfg(v, 16'h8000, 0);
    get_sample(s);
    chk("gate_off_all", s, 0);
    gate = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      get_sample(s);
      chk($sformatf("sq4_%0d", k), s, (k % 2) ? 8188 : 0);
    end

    // Voice 2 triangle, 0x2000 per sample.
    gate = 4'b0000;
    cfg(2, 16'h2000, 2);
    get_sample(s);
    chk("gate_off_tri", s, 0);
    gate = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      get_sample(s);
      chk($sformatf("tri_%0d", k), s, tri_exp[k]);
    end

    // Two writes in one period: the later one wins.
    gate = 4'b0000;
    get_sample(s);
    chk("gate_off_sh", s, 0);
    repeat (2) @(negedge clk);
    cfg(0, 16'h0400, 1);
    @(negedge clk);
    cfg(0, 16'h1000, 1);
    gate = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      get_sample(s);
      chk($sformatf("shadow_%0d", k), s, 128 * k);
    end

    // Gate drop clears the phase; re-raise restarts from 0.
    gate = 4'b0000;
    get_sample(s);
    chk("gate_drop", s, 0);
    gate = 4'b0001;
    get_sample(s);
    chk("gate_restart0", s, 0);
    get_sample(s);
    chk("gate_restart1", s, 128);

    // Reset on the second sweep cycle.
    begin
      int n;
      n = 0;
      while (!busy && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("busy_seen", int'(busy), 1);
      chk("held_sample", int'(sample_out), 128);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_sample_out", int'(sample_out), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_valid", int'(sample_valid), 0);
      rst = 1'b0;
    end
    idle_window("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
